// File: rtl/uno_render_pkg.sv
// Shared types and default geometry for the card glyph scheduler.
// Slot entries are packed so the whole shadow table can be copied in one cycle.
package uno_render_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int CARD_W    = 30;
    localparam int CARD_H    = 50;

    typedef struct packed {
        logic       en;
        logic [3:0] value;
        logic [1:0] color;
        logic [9:0] x;
        logic [9:0] y;
    } slot_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_COMMIT = 1'b1
    } state_e;

endpackage

// File: rtl/card_hit_check.sv
// Inclusive box test of one card slot against the current scan position.
// Upper bounds are formed in 11 bits so a card near the right/bottom edge never wraps.
module card_hit_check
    import uno_render_pkg::*;
#(
    parameter int BOX_W = CARD_W,
    parameter int BOX_H = CARD_H
) (
    input  slot_t      slot,
    input  logic [9:0] x_cnt,
    input  logic [9:0] y_cnt,
    input  logic       excl,
    output logic       hit
);

    logic [10:0] x_hi;
    logic [10:0] y_hi;

    assign x_hi = {1'b0, slot.x} + 11'(BOX_W);
    assign y_hi = {1'b0, slot.y} + 11'(BOX_H);

    assign hit = slot.en && !excl
              && (x_cnt >= slot.x) && ({1'b0, x_cnt} <= x_hi)
              && (y_cnt >= slot.y) && ({1'b0, y_cnt} <= y_hi);

endmodule

// File: rtl/card_render_sched.sv
// Double-buffered card slot table with per-pixel priority selection for the glyph renderer.
// Writes land in the shadow table; a frame_start commits it to the active table in one cycle.
module card_render_sched #(
    parameter int NUM_SLOTS = uno_render_pkg::NUM_SLOTS,
    parameter int CARD_W    = uno_render_pkg::CARD_W,
    parameter int CARD_H    = uno_render_pkg::CARD_H
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [9:0] x_cnt,
    input  logic [9:0] y_cnt,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_slot,
    input  logic       wr_en,
    input  logic [3:0] wr_value,
    input  logic [1:0] wr_color,
    input  logic [9:0] wr_x,
    input  logic [9:0] wr_y,
    input  logic       hl_valid,
    input  logic [2:0] hl_slot,
    output logic       sel_hit,
    output logic [2:0] sel_slot,
    output logic [3:0] sel_value,
    output logic [1:0] sel_color,
    output logic [9:0] sel_x_pin,
    output logic [9:0] sel_y_pin
);
    import uno_render_pkg::*;

    state_e     state_q, state_d;
    logic       wr_ready_q, wr_ready_d;
    slot_t      shadow_q [NUM_SLOTS];
    slot_t      shadow_d [NUM_SLOTS];
    slot_t      active_q [NUM_SLOTS];
    slot_t      active_d [NUM_SLOTS];
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic       hl_en_q, hl_en_d;
    logic [2:0] hl_slot_q, hl_slot_d;

    logic       sel_hit_q, sel_hit_d;
    logic [2:0] sel_slot_q, sel_slot_d;
    logic [3:0] sel_value_q, sel_value_d;
    logic [1:0] sel_color_q, sel_color_d;
    logic [9:0] sel_x_q, sel_x_d;
    logic [9:0] sel_y_q, sel_y_d;

    logic [NUM_SLOTS-1:0] hit;
    logic [NUM_SLOTS-1:0] excl;
    slot_t                wr_entry;
    logic                 wr_fire;

    assign wr_entry = {wr_en, wr_value, wr_color, wr_x, wr_y};
    assign wr_fire  = wr_valid && wr_ready_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        assign excl[g] = hl_en_q && frame_cnt_q[5] && (int'(hl_slot_q) == g);

        card_hit_check #(
            .BOX_W (CARD_W),
            .BOX_H (CARD_H)
        ) u_hit (
            .slot  (active_q[g]),
            .x_cnt (x_cnt),
            .y_cnt (y_cnt),
            .excl  (excl[g]),
            .hit   (hit[g])
        );
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (frame_start) state_d = S_COMMIT;
        end else begin
            state_d = S_IDLE;
        end
        wr_ready_d = (state_d == S_IDLE);

        // Out-of-range slot numbers match no entry, so the write is simply dropped.
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_fire && (int'(wr_slot) == i)) shadow_d[i] = wr_entry;
        end

        active_d = active_q;
        if (state_q == S_COMMIT) active_d = shadow_q;

        frame_cnt_d = frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;
        hl_en_d     = hl_en_q || hl_valid;
        hl_slot_d   = hl_valid ? hl_slot : hl_slot_q;
    end

    // Scan from the highest index down so the lowest hitting slot has the final say.
    always_comb begin
        sel_hit_d   = 1'b0;
        sel_slot_d  = '0;
        sel_value_d = '0;
        sel_color_d = '0;
        sel_x_d     = '0;
        sel_y_d     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_hit_d   = 1'b1;
                sel_slot_d  = 3'(i);
                sel_value_d = active_q[i].value;
                sel_color_d = active_q[i].color;
                sel_x_d     = active_q[i].x;
                sel_y_d     = active_q[i].y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ready_q  <= 1'b1;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            frame_cnt_q <= '0;
            hl_en_q     <= 1'b0;
            hl_slot_q   <= '0;
            sel_hit_q   <= 1'b0;
            sel_slot_q  <= '0;
            sel_value_q <= '0;
            sel_color_q <= '0;
            sel_x_q     <= '0;
            sel_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ready_q  <= wr_ready_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            frame_cnt_q <= frame_cnt_d;
            hl_en_q     <= hl_en_d;
            hl_slot_q   <= hl_slot_d;
            sel_hit_q   <= sel_hit_d;
            sel_slot_q  <= sel_slot_d;
            sel_value_q <= sel_value_d;
            sel_color_q <= sel_color_d;
            sel_x_q     <= sel_x_d;
            sel_y_q     <= sel_y_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign sel_hit   = sel_hit_q;
    assign sel_slot  = sel_slot_q;
    assign sel_value = sel_value_q;
    assign sel_color = sel_color_q;
    assign sel_x_pin = sel_x_q;
    assign sel_y_pin = sel_y_q;

endmodule

// File: tb/tb_card_render_sched.sv
// Directed bench for card_render_sched: expected selections are queued with each probe
// and popped when the registered output appears one cycle later.
module tb_card_render_sched;

    typedef struct packed {
        logic       hit;
        logic [2:0] slot;
        logic [3:0] value;
        logic [1:0] color;
        logic [9:0] x;
        logic [9:0] y;
    } sel_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] x_cnt = '0;
    logic [9:0] y_cnt = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_slot = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_value = '0;
    logic [1:0] wr_color = '0;
    logic [9:0] wr_x = '0;
    logic [9:0] wr_y = '0;
    logic       hl_valid = 1'b0;
    logic [2:0] hl_slot = '0;
    logic       sel_hit;
    logic [2:0] sel_slot;
    logic [3:0] sel_value;
    logic [1:0] sel_color;
    logic [9:0] sel_x_pin;
    logic [9:0] sel_y_pin;

    int         total = 0;
    int         bad = 0;
    sel_t       exp_q[$];
    logic [5:0] fc = '0;
    localparam sel_t MISS = '0;

    card_render_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .x_cnt       (x_cnt),
        .y_cnt       (y_cnt),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_slot     (wr_slot),
        .wr_en       (wr_en),
        .wr_value    (wr_value),
        .wr_color    (wr_color),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .hl_valid    (hl_valid),
        .hl_slot     (hl_slot),
        .sel_hit     (sel_hit),
        .sel_slot    (sel_slot),
        .sel_value   (sel_value),
        .sel_color   (sel_color),
        .sel_x_pin   (sel_x_pin),
        .sel_y_pin   (sel_y_pin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sel_t hit_e(input logic [2:0] s, input logic [3:0] v, input logic [1:0] c,
                                   input logic [9:0] x, input logic [9:0] y);
        return {1'b1, s, v, c, x, y};
    endfunction

    function automatic sel_t outs();
        return {sel_hit, sel_slot, sel_value, sel_color, sel_x_pin, sel_y_pin};
    endfunction

    task automatic probe(input string tag, input logic [9:0] px, input logic [9:0] py, input sel_t e);
        sel_t exp_v;
        x_cnt = px;
        y_cnt = py;
        exp_q.push_back(e);
        tick();
        exp_v = exp_q.pop_front();
        chk(tag, 32'(outs()), 32'(exp_v));
    endtask

    task automatic do_write(input logic [2:0] s, input logic en, input logic [3:0] v,
                            input logic [1:0] c, input logic [9:0] x, input logic [9:0] y,
                            output int waited);
        logic acc;
        acc      = 1'b0;
        waited   = 0;
        wr_valid = 1'b1;
        wr_slot  = s;
        wr_en    = en;
        wr_value = v;
        wr_color = c;
        wr_x     = x;
        wr_y     = y;
        for (int n = 0; n < 8; n++) begin
            acc = wr_ready;
            tick();
            if (acc) break;
            waited++;
        end
        wr_valid = 1'b0;
        chk("wr_accept", 32'(acc), 32'd1);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fc++;
        chk("ready_commit", 32'(wr_ready), 32'd0);
        tick();
        chk("ready_idle", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        int w;

        // Reset state, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'(MISS));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(wr_ready), 32'd1);

        // Basic hit, box edges inclusive.
        do_write(3'd0, 1'b1, 4'd5, 2'd2, 10'd100, 10'd200, w);
        pulse_frame();
        probe("s0_corner", 10'd100, 10'd200, hit_e(3'd0, 4'd5, 2'd2, 10'd100, 10'd200));
        probe("s0_far", 10'd130, 10'd250, hit_e(3'd0, 4'd5, 2'd2, 10'd100, 10'd200));
        probe("s0_x_out", 10'd131, 10'd200, MISS);
        probe("s0_y_out", 10'd100, 10'd251, MISS);

        // Priority: lowest index wins, disabled slot drops out.
        do_write(3'd1, 1'b1, 4'd1, 2'd1, 10'd290, 10'd290, w);
        do_write(3'd3, 1'b1, 4'd3, 2'd3, 10'd280, 10'd280, w);
        pulse_frame();
        probe("prio_1", 10'd300, 10'd300, hit_e(3'd1, 4'd1, 2'd1, 10'd290, 10'd290));
        probe("only_3", 10'd285, 10'd285, hit_e(3'd3, 4'd3, 2'd3, 10'd280, 10'd280));
        do_write(3'd1, 1'b0, 4'd1, 2'd1, 10'd290, 10'd290, w);
        probe("prio_pre_commit", 10'd300, 10'd300, hit_e(3'd1, 4'd1, 2'd1, 10'd290, 10'd290));
        pulse_frame();
        probe("prio_3", 10'd300, 10'd300, hit_e(3'd3, 4'd3, 2'd3, 10'd280, 10'd280));

        // Shadow write stays invisible until committed.
        do_write(3'd2, 1'b1, 4'd7, 2'd0, 10'd500, 10'd100, w);
        probe("s2_uncommitted", 10'd510, 10'd110, MISS);

        // Write presented in the frame_start cycle rides into the same commit.
        wr_valid = 1'b1; wr_slot = 3'd2; wr_en = 1'b1; wr_value = 4'd8;
        wr_color = 2'd1; wr_x = 10'd500; wr_y = 10'd100;
        frame_start = 1'b1;
        chk("ready_fs_cycle", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        frame_start = 1'b0;
        fc++;
        chk("ready_commit_fs", 32'(wr_ready), 32'd0);
        tick();
        probe("s2_fs_write", 10'd510, 10'd110, hit_e(3'd2, 4'd8, 2'd1, 10'd500, 10'd100));

        // Write held through COMMIT waits one cycle, then lands in shadow only.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fc++;
        do_write(3'd4, 1'b1, 4'd4, 2'd3, 10'd700, 10'd600, w);
        chk("stall_wait", 32'(w), 32'd1);
        probe("s4_uncommitted", 10'd710, 10'd610, MISS);
        pulse_frame();
        probe("s4_active", 10'd710, 10'd610, hit_e(3'd4, 4'd4, 2'd3, 10'd700, 10'd600));

        // Box at the right edge must not wrap back to column 0.
        do_write(3'd5, 1'b1, 4'd9, 2'd1, 10'd1000, 10'd10, w);
        pulse_frame();
        probe("edge_1023", 10'd1023, 10'd10, hit_e(3'd5, 4'd9, 2'd1, 10'd1000, 10'd10));
        probe("edge_1000_ybot", 10'd1000, 10'd60, hit_e(3'd5, 4'd9, 2'd1, 10'd1000, 10'd10));
        probe("edge_y_out", 10'd1000, 10'd61, MISS);
        for (int xi = 0; xi < 1000; xi++) begin
            probe("no_wrap", 10'(xi), 10'd10, MISS);
        end

        // Highlight blink: slot 0 hidden while frame_cnt[5] is set, slot 1 beneath shows.
        do_write(3'd1, 1'b1, 4'd6, 2'd2, 10'd110, 10'd210, w);
        pulse_frame();
        probe("hl_off", 10'd115, 10'd215, hit_e(3'd0, 4'd5, 2'd2, 10'd100, 10'd200));
        hl_valid = 1'b1;
        hl_slot  = 3'd0;
        tick();
        hl_valid = 1'b0;
        for (int k = 0; k < 70; k++) begin
            pulse_frame();
            probe("hl_blink", 10'd115, 10'd215,
                  fc[5] ? hit_e(3'd1, 4'd6, 2'd2, 10'd110, 10'd210)
                        : hit_e(3'd0, 4'd5, 2'd2, 10'd100, 10'd200));
        end

        // frame_start during COMMIT: counted, but no second commit.
        frame_start = 1'b1;
        tick();
        fc++;
        chk("dbl_fs_commit", 32'(wr_ready), 32'd0);
        tick();
        frame_start = 1'b0;
        fc++;
        chk("dbl_fs_idle", 32'(wr_ready), 32'd1);
        tick();
        chk("dbl_fs_still_idle", 32'(wr_ready), 32'd1);
        for (int k = 0; k < 40; k++) begin
            pulse_frame();
            probe("hl_after_dbl", 10'd115, 10'd215,
                  fc[5] ? hit_e(3'd1, 4'd6, 2'd2, 10'd110, 10'd210)
                        : hit_e(3'd0, 4'd5, 2'd2, 10'd100, 10'd200));
        end

        // Highlight moved to slot 7 (empty): slot 0 stays visible even in a hidden phase.
        hl_valid = 1'b1;
        hl_slot  = 3'd7;
        tick();
        hl_valid = 1'b0;
        for (int k = 0; k < 64 && !fc[5]; k++) pulse_frame();
        chk("hl7_phase", 32'(fc[5]), 32'd1);
        probe("hl7_slot0_shown", 10'd115, 10'd215, hit_e(3'd0, 4'd5, 2'd2, 10'd100, 10'd200));

        // Asynchronous reset in the middle of COMMIT.
        tick();
        chk("pre_reset_hit", 32'(sel_hit), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_commit", 32'(outs()), 32'(MISS));
        #1 rst_n = 1'b1;
        fc = '0;
        tick();
        chk("ready_post_reset", 32'(wr_ready), 32'd1);
        probe("active_clear_0", 10'd115, 10'd215, MISS);
        probe("active_clear_1", 10'd100, 10'd200, MISS);
        pulse_frame();
        probe("shadow_clear", 10'd1023, 10'd10, MISS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/card_render_sched.md
CARD_RENDER_SCHED -- requirements
Module: card_render_sched

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of card slots scheduled onto the shared glyph renderer.
REQ-002 Parameter CARD_W, default 30; parameter CARD_H, default 50: glyph box extents; the box is inclusive, so a slot covers CARD_W+1 x CARD_H+1 pixels.
REQ-003 clk  in  1  pixel clock.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 frame_start  in  1  single-cycle pulse at the start of vertical blank.
REQ-006 x_cnt, y_cnt  in  10 each  current scan position.
REQ-007 wr_valid  in  1; wr_ready  out  1  slot-write handshake.
REQ-008 wr_slot  in  3; wr_en  in  1; wr_value  in  4; wr_color  in  2; wr_x, wr_y  in  10 each  slot-write payload.
REQ-009 hl_valid  in  1; hl_slot  in  3  highlight select, written in the same cycle it is presented.
REQ-010 sel_hit  out  1; sel_slot  out  3; sel_value  out  4; sel_color  out  2; sel_x_pin, sel_y_pin  out  10 each  renderer drive.

Function
REQ-011 State machine IDLE/COMMIT: a frame_start pulse in IDLE moves to COMMIT; COMMIT returns to IDLE after exactly 1 cycle.
REQ-012 wr_ready is 1 in IDLE and 0 in COMMIT.
REQ-013 A write is accepted when wr_valid and wr_ready are both 1; it updates the shadow table entry wr_slot {en, value, color, x, y}.
REQ-014 COMMIT copies the whole shadow table into the active table in one cycle.
REQ-015 A write accepted in the frame_start cycle lands in shadow before the copy and is visible in the frame that follows.
REQ-016 wr_valid held during COMMIT stalls until IDLE; payload must stay stable while stalled.
REQ-017 wr_slot >= NUM_SLOTS: accepted, no table change.
REQ-018 Hit test per active slot: en && x <= x_cnt <= x+CARD_W && y <= y_cnt <= y+CARD_H.
REQ-019 Hit-test sums are 11-bit, so a box near 1023 does not wrap.
REQ-020 Among hitting slots, the lowest index wins.
REQ-021 Selection outputs are registered with 1-cycle latency relative to x_cnt/y_cnt.
REQ-022 With no hit: sel_hit=0 and all sel_* fields = 0.
REQ-023 frame_cnt is a 6-bit counter that increments on each frame_start and wraps from 63 to 0.
REQ-024 While hl_en=1 and frame_cnt[5]=1, slot hl_slot is excluded from the hit test, so a lower-priority overlapping slot can win.
REQ-025 hl_valid with hl_slot=7 and NUM_SLOTS=8 is legal.
REQ-026 A frame_start that arrives during COMMIT is ignored for the state machine but still increments frame_cnt.

Reset
REQ-027 On rst_n low, without waiting for clk: state=IDLE, shadow and active tables all zero (en=0), frame_cnt=0, hl_en=0, hl_slot=0, and all sel_* outputs 0.
REQ-028 wr_ready=1 from the first cycle after rst_n deasserts.
REQ-029 A reset mid-COMMIT aborts the copy and leaves the active table zeroed.

Structure
REQ-030 Package uno_render_pkg shall hold NUM_SLOTS, CARD_W, CARD_H, the slot_t packed struct {en, value[3:0], color[1:0], x[9:0], y[9:0]}, and the state enum.
REQ-031 Sub-module card_hit_check performs the single-slot inclusive box compare and is instantiated NUM_SLOTS times.
REQ-032 The target size is 120-400 RTL lines.

Verification
REQ-033 Reset, then write slot 0 {en=1, v=5, c=2, x=100, y=200}, then pulse frame_start -> wr_ready=0 for exactly 1 cycle; at (100,200) and (130,250), sel_hit=1, sel_value=5, sel_color=2 one cycle later; at (131,200), sel_hit=0.
REQ-034 Slots 1 and 3 overlap at (300,300) -> sel_slot=1; disable slot 1 and pulse frame_start -> sel_slot=3.
REQ-035 Write slot 2 without frame_start -> output unchanged; write asserted in the frame_start cycle -> new data active after COMMIT; wr_valid held through COMMIT -> accepted on the following cycle.
REQ-036 Slot x=1000 -> hit at x_cnt=1023; no hit at x_cnt=0..999 (no wrap).
REQ-037 Highlight slot 0 -> hidden in frames 32-63 and shown in frames 0-31, with slot 1 under it winning while hidden; frame_cnt wraps 63 to 0.
REQ-038 Assert rst_n during COMMIT -> all outputs 0 immediately (asynchronous); active table empty after release.
